// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: write-back value in, scanned display lines out
// master: write-back side (drives ResultW/result_valid/blank_lz, reads display lines)
// slave : scan controller (reads write-back inputs, drives an/display/shown_value/frame_done)
interface seg7_scan_ctrl_if;
    logic [31:0] ResultW;
    logic        result_valid;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  display;
    logic [31:0] shown_value;
    logic        frame_done;
    modport master (
        output ResultW, result_valid, blank_lz,
        input  an, display, shown_value, frame_done
    );
    modport slave (
        input  ResultW, result_valid, blank_lz,
        output an, display, shown_value, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: tear-free 8-digit hex scan controller for a common-anode 7-segment display
// clk, rst (async, active-high)
// bus.ResultW/result_valid: value captured, committed only at frame boundaries
// bus.blank_lz: leading-zero blanking enable
// bus.an (active-low anodes), bus.display (a..g, bit6=a), bus.shown_value, bus.frame_done
module seg7_scan_ctrl #(
    parameter int DIGITS         = 8,
    parameter int PRESCALE       = 100000,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input logic              clk,
    input logic              rst,
    seg7_scan_ctrl_if.slave  bus
);
    localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [6:0] OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [31:0] MASK = DIGITS == 8 ? 32'hFFFF_FFFF : (32'h1 << (4 * DIGITS)) - 32'h1;
    localparam logic [6:0] SEG [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   pend_val_q, pend_val_d, shown_q, shown_d;
    logic          pend_q, pend_d, done_q, done_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    disp_q, disp_d;
    logic          tick, wrap, bnd, blank;
    logic [4:0]    shift;
    logic [6:0]    seg;

    always_comb begin
        tick       = cnt_q == CW'(PRESCALE - 1);
        wrap       = idx_q == 3'(DIGITS - 1);
        bnd        = tick && wrap;
        shift      = {idx_q, 2'b00};
        // blank when this nibble and every more-significant displayed nibble are zero
        blank      = bus.blank_lz && idx_q != 3'd0 && ((shown_q & MASK) >> shift) == 32'h0;
        seg        = SEG[shown_q[shift +: 4]];
        cnt_d      = tick ? '0 : cnt_q + CW'(1);
        idx_d      = tick ? (wrap ? 3'd0 : idx_q + 3'd1) : idx_q;
        // a valid on the boundary cycle re-arms pending after the old value commits
        pend_val_d = bus.result_valid ? bus.ResultW : pend_val_q;
        pend_d     = bus.result_valid ? 1'b1 : (bnd ? 1'b0 : pend_q);
        shown_d    = bnd && pend_q ? pend_val_q : shown_q;
        done_d     = bnd;
        an_d       = blank ? 8'hFF : ~(8'h01 << idx_q);
        disp_d     = blank ? OFF : (SEG_ACTIVE_LOW ? ~seg : seg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= 3'd0;
            pend_val_q <= 32'h0;
            pend_q     <= 1'b0;
            shown_q    <= 32'h0;
            done_q     <= 1'b0;
            an_q       <= 8'hFF;
            disp_q     <= OFF;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            shown_q    <= shown_d;
            done_q     <= done_d;
            an_q       <= an_d;
            disp_q     <= disp_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.display     = disp_q;
    assign bus.shown_value = shown_q;
    assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized scoreboard bench for seg7_scan_ctrl (PRESCALE=4, DIGITS=8, active-low segments)
module tb_seg7_scan_ctrl;
    localparam int PRE = 4;
    localparam int DIG = 8;
    localparam int FRAME = PRE * DIG;
    localparam logic [6:0] HEX [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                                        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_ctrl_if bus ();
    seg7_scan_ctrl #(.DIGITS(DIG), .PRESCALE(PRE), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int nchk = 0;
    int nfail = 0;
    logic [31:0] exp_q[$];

    // stimulus-side frame model
    int e = 0;
    logic m_pend = 1'b0;
    logic [31:0] m_val = 32'h0;
    logic [31:0] m_sh = 32'h0;
    logic bl_cur = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // one clock of stimulus; the commit model resolves what the next edge does
    task automatic cyc(input logic v, input logic [31:0] val, input logic bl);
        bus.result_valid = v;
        bus.ResultW = val;
        bus.blank_lz = bl;
        if ((e + 1) % FRAME == 0) begin
            if (m_pend) m_sh = m_val;
            exp_q.push_back(m_sh);
            m_pend = v;
            if (v) m_val = val;
        end else if (v) begin
            m_pend = 1'b1;
            m_val = val;
        end
        @(posedge clk);
        e++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, bl_cur);
    endtask

    task automatic go_to(input int ph);
        while (e % FRAME != ph) cyc(1'b0, 32'h0, bl_cur);
    endtask

    // monitor: expected display lines derived from elapsed edges and the committed value
    int k = 0;
    logic bl_s = 1'b0;
    logic [31:0] cur = 32'h0;
    initial begin
        int d;
        logic blank;
        logic [7:0] an_e;
        logic [6:0] ds_e;
        forever begin
            @(posedge clk);
            bl_s = bus.blank_lz;
            if (rst) begin
                k = 0;
                cur = 32'h0;
            end else k++;
            @(negedge clk);
            if (!rst) begin
                if (k == 0) begin
                    an_e = 8'hFF;
                    ds_e = 7'h7F;
                end else begin
                    d = ((k - 1) / PRE) % DIG;
                    blank = bl_s && d > 0 && (cur >> (4 * d)) == 32'h0;
                    an_e = blank ? 8'hFF : ~(8'h01 << d);
                    ds_e = blank ? 7'h7F : ~HEX[(cur >> (4 * d)) & 32'hF];
                end
                chk("an", {24'h0, bus.an}, {24'h0, an_e});
                chk("display", {25'h0, bus.display}, {25'h0, ds_e});
                chk("frame_done", {31'h0, bus.frame_done}, {31'h0, k > 0 && k % FRAME == 0});
                if (bus.frame_done) begin
                    if (exp_q.size() == 0) begin
                        nchk++;
                        nfail++;
                        $display("FAIL commit_queue at %0t: got frame_done with no expected commit", $time);
                    end else cur = exp_q.pop_front();
                end
                chk("shown_value", bus.shown_value, cur);
            end
        end
    end

    initial begin
        logic [31:0] rv;
        bus.result_valid = 1'b0;
        bus.ResultW = 32'h0;
        bus.blank_lz = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        e = 0;
        idle(2 * FRAME);
        // mid-frame capture of a full-width value
        go_to(10);
        cyc(1'b1, 32'h89AB_CDEF, bl_cur);
        idle(2 * FRAME);
        // leading-zero blanking
        bl_cur = 1'b1;
        go_to(3);
        cyc(1'b1, 32'h0000_00A5, bl_cur);
        idle(2 * FRAME);
        // last valid in a frame wins
        go_to(4);
        cyc(1'b1, 32'h1, bl_cur);
        idle(5);
        cyc(1'b1, 32'h2, bl_cur);
        idle(2 * FRAME);
        // valid exactly on the boundary cycle while a value is pending
        go_to(5);
        cyc(1'b1, 32'h2, bl_cur);
        go_to(FRAME - 1);
        cyc(1'b1, 32'h3, bl_cur);
        idle(2 * FRAME);
        // randomized traffic, sometimes with short values so blanking kicks in
        for (int i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(0, 15) == 0) bl_cur = ~bl_cur;
            rv = $urandom >> (4 * $urandom_range(0, 7));
            cyc($urandom_range(0, 6) == 0, rv, bl_cur);
        end
        idle(FRAME);
        // asynchronous reset while digit 5 is lit and a value is pending
        bl_cur = 1'b0;
        go_to(18);
        cyc(1'b1, 32'hDEAD_BEEF, bl_cur);
        go_to(21);
        #2 rst = 1'b1;
        #1;
        chk("rst_an", {24'h0, bus.an}, 32'hFF);
        chk("rst_display", {25'h0, bus.display}, 32'h7F);
        chk("rst_shown", bus.shown_value, 32'h0);
        chk("rst_frame_done", {31'h0, bus.frame_done}, 32'h0);
        exp_q.delete();
        m_pend = 1'b0;
        m_val = 32'h0;
        m_sh = 32'h0;
        bus.result_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        e = 0;
        idle(2 * FRAME + 3);
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display, showing the processor's 32-bit write-back result as 8 hex digits.
- Captures the write-back value on a valid strobe and commits it only at frame boundaries, so the display never tears.
- Steps through the digits with a prescaled refresh counter and drives the anode and segment lines through a built-in hex-to-segment decode.
- Sits between the pipeline write-back stage and the board display pins.

Parameters:
- DIGITS, 8: number of scanned digits, legal range 1..8; digit i shows ResultW nibble [4i+3:4i].
- PRESCALE, 100000: clk cycles each digit stays lit, legal range >= 1.
- SEG_ACTIVE_LOW, 1: 1 drives lit segments as 0; 0 drives lit segments as 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ResultW  in  32  write-back result to display
- result_valid  in  1  ResultW qualifier; high for one or more cycles
- blank_lz  in  1  leading-zero blanking enable, sampled every cycle
- an  out  8  digit anodes, active-low, one-hot-cold; bits >= DIGITS held 1
- display  out  7  segments, bit6=a ... bit0=g, polarity per SEG_ACTIVE_LOW
- shown_value  out  32  value currently being displayed
- frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async assert, sync release): internal state and outputs take these values.
  - Prescaler count = 0, digit index idx = 0.
  - pending_val = 0, pending = 0, shown_value = 0.
  - an = 8'hFF; display = all segments off; frame_done = 0.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - tick = (count == PRESCALE-1); on tick, count goes to 0.
  - PRESCALE = 1 produces a tick every cycle.
- Digit index:
  - On tick, idx advances by 1; when idx == DIGITS-1 it wraps to 0.
  - DIGITS = 1 keeps idx at 0, and every tick is a wrap.
- Frame boundary: the cycle where tick is high and idx == DIGITS-1.
- Capture:
  - Any cycle with result_valid high loads pending_val <= ResultW and sets pending = 1.
  - Repeated valids before a frame boundary overwrite pending_val; last one wins.
- Commit (frame boundary):
  - If pending = 1, shown_value <= pending_val.
  - frame_done = 1 on the following cycle only.
  - If result_valid is also high on the boundary cycle:
    - The old pending_val commits.
    - The new ResultW loads into pending_val.
    - pending stays 1, so that value commits at the next boundary.
  - If result_valid is low on the boundary cycle, pending clears to 0.
- Decode table (active-high form, a..g), segment codes per nibble:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001
  - 4 = 0110011, 5 = 1011011, 6 = 1011111, 7 = 1110000
  - 8 = 1111111, 9 = 1110011, A = 1110111, b = 0011111
  - C = 1001110, d = 0111101, E = 1001111, F = 1000111
  - Inverted when SEG_ACTIVE_LOW = 1.
- Leading-zero blanking:
  - Digit i is blank when blank_lz = 1, i > 0, and shown_value nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - For a blank digit: an = 8'hFF and display = all off.
- Output registration:
  - an and display are registered from the current idx, shown_value and blank_lz, so they lag idx by 1 cycle.
  - For a non-blank digit: an = ~(8'b1 << idx) and display = decoded nibble.
  - First clock edge after reset release: an = 8'hFE, display = decode of nibble 0 of shown_value (0).
- Digit switch: exactly one anode (or none, for a blank digit) is low in any cycle; no two-digit overlap.
- Reset mid-frame: everything clears immediately and asynchronously; the pending value is discarded, and scanning restarts at digit 0 after release.

Test Plan:
- Reset release, PRESCALE=4, DIGITS=8, SEG_ACTIVE_LOW=1, no valid:
  - an cycles FE, FD, FB, ... 7F, each for 4 clks.
  - display = 0000001 (decode of 0) on every digit.
  - frame_done pulses every 32 clks.
- Pulse result_valid with ResultW=32'h89ABCDEF mid-frame:
  - shown_value stays 0 until the boundary, then becomes 89ABCDEF.
  - Digit 0 shows F (0111000 active-low); digit 7 shows 8 (0000000).
- blank_lz=1, ResultW=32'h0000_00A5 committed:
  - Digits 0 and 1 are lit, showing 5 and A.
  - During digits 2..7, an=FF and display=1111111.
- Valid pulses with 32'h1 and then 32'h2 within one frame: only 32'h2 commits.
- Valid with 32'h3 asserted exactly on the boundary cycle, while pending holds 32'h2:
  - shown_value = 2 at that boundary.
  - shown_value = 3 at the next boundary.
- Assert rst while at digit 5 with pending set:
  - Outputs go to reset values within the same cycle, with no clock edge needed.
  - After release, scan restarts at FE and shown_value = 0.
